// File: rtl/mem_reader_pkg.sv
// Shared definitions for the host-side parallel memory reader.
// Contents:
//   PAR_AW / PAR_DW : widths of the processor's parallel debug port
//                     (parallelAddress / q).
//   LAT_W           : width of the read-latency counter (covers RD_LAT 1..15).
//   state_t         : reader FSM states.
package mem_reader_pkg;

    localparam int PAR_AW = 24;
    localparam int PAR_DW = 24;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/read_latency_timer.sv
// Loadable down-counter with a zero flag, used to wait out a fixed memory
// read latency. Reusable by any host-side peripheral that has to pause a
// known number of cycles after driving an address.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset (count returns to 0)
//   i_load       : load i_load_value (takes priority over counting)
//   i_load_value : value to load
//   i_enable     : decrement by one per cycle while non-zero
//   o_zero       : count is zero
module read_latency_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_enable,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            // Saturate at zero so a long stay in the enabled state is harmless.
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/parallel_mem_reader.sv
// Host-side reader for the processor's parallel debug read port. A start
// pulse sweeps word_count consecutive addresses from base_addr; each word is
// read after RD_LAT cycles and offered on a valid/ready stream together with
// its offset (m_index) and an end-of-sweep flag (m_last).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a sweep (IDLE only) / abandon the current sweep
//   base_addr       : first address of the sweep (latched on start)
//   word_count      : number of words (latched on start; 0 = empty sweep)
//   rd_addr/rd_data : processor parallelAddress / q
//   m_valid/m_ready : output stream handshake
//   m_data/m_index  : captured word and its offset from base_addr
//   m_last          : final word of the sweep
//   busy            : not idle
//   done            : one-cycle pulse after a sweep completes or is aborted
// RD_LAT must lie in 1..15 (the latency counter is LAT_W bits wide).
module parallel_mem_reader
    import mem_reader_pkg::*;
#(
    parameter int AW     = PAR_AW,
    parameter int DW     = PAR_DW,
    parameter int CW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_count,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] m_index,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    logic [AW-1:0] r_rd_addr;
    logic [DW-1:0] r_m_data;
    logic [CW-1:0] r_index;
    logic [CW-1:0] r_remaining;
    logic          r_m_valid;
    logic          r_m_last;
    logic          r_busy;
    logic          r_done;

    logic w_handshake;
    logic w_accept;
    logic w_next_word;
    logic w_timer_load;
    logic w_timer_en;
    logic w_lat_zero;

    assign w_handshake = r_m_valid && m_ready;
    // A non-empty sweep is accepted only from IDLE.
    assign w_accept    = (r_state == ST_IDLE) && start && (word_count != '0);
    // Handshake on a word that is not the last one: move to the next address.
    assign w_next_word = (r_state == ST_HOLD) && !abort && w_handshake
                         && (r_remaining > CW'(1));

    // The timer is reloaded in the same edge that puts a new address on
    // rd_addr, so its count tracks the cycles that address has been stable.
    assign w_timer_load = w_accept || w_next_word;
    assign w_timer_en   = (r_state == ST_WAIT);

    read_latency_timer #(
        .W (LAT_W)
    ) u_lat_timer (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_timer_load),
        .i_load_value (LAT_W'(RD_LAT)),
        .i_enable     (w_timer_en),
        .o_zero       (w_lat_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_m_data    <= '0;
            r_index     <= '0;
            r_remaining <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rd_addr   <= base_addr;
                        r_remaining <= word_count;
                        r_index     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WAIT;
                    end else if (start) begin
                        // Empty sweep: report completion without any words.
                        r_busy  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_lat_zero) begin
                        r_m_data  <= rd_data;
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_remaining == CW'(1));
                        r_state   <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    // Abort wins over a simultaneous handshake: the word is dropped.
                    if (abort) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_handshake) begin
                        r_m_valid <= 1'b0;
                        if (r_remaining > CW'(1)) begin
                            r_remaining <= r_remaining - CW'(1);
                            r_index     <= r_index + CW'(1);
                            r_rd_addr   <= r_rd_addr + AW'(1);
                            r_state     <= ST_WAIT;
                        end else begin
                            r_m_last <= 1'b0;
                            r_state  <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // done is registered, so it appears in the cycle after DONE.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr = r_rd_addr;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_index = r_index;
    assign m_last  = r_m_last;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_parallel_mem_reader.sv
// Scoreboard bench for parallel_mem_reader. Instance A (RD_LAT=1) runs
// directed and random sweeps checked by a negedge monitor against a queue of
// expected words; instance B (RD_LAT=3) checks latency and mid-sweep reset.
module tb_parallel_mem_reader;

    localparam int AW = 24;
    localparam int DW = 24;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (RD_LAT = 1) ----------------
    logic          rst, start, abort;
    logic [AW-1:0] base_addr, rd_addr;
    logic [CW-1:0] word_count, m_index;
    logic [DW-1:0] rd_data, m_data;
    logic          m_valid, m_ready, m_last, busy, done;

    parallel_mem_reader #(.AW(AW), .DW(DW), .CW(CW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last), .busy(busy), .done(done)
    );

    // ---------------- instance B (RD_LAT = 3) ----------------
    logic          b_rst, b_start, b_abort, b_m_ready;
    logic [AW-1:0] b_base, b_rd_addr;
    logic [CW-1:0] b_count, b_m_index;
    logic [DW-1:0] b_rd_data, b_m_data;
    logic          b_m_valid, b_m_last, b_busy, b_done;

    parallel_mem_reader #(.AW(AW), .DW(DW), .CW(CW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
        .base_addr(b_base), .word_count(b_count),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .m_index(b_m_index), .m_last(b_m_last), .busy(b_busy), .done(b_done)
    );

    // ---------------- memory models ----------------
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 24'hA5A5A5;
    endfunction

    logic [DW-1:0] a_pipe;
    always @(posedge clk) a_pipe <= mem_word(rd_addr);
    assign rd_data = a_pipe;

    logic [DW-1:0] b_pipe [3];
    always @(posedge clk) begin
        b_pipe[0] <= mem_word(b_rd_addr);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_rd_data = b_pipe[2];

    // ---------------- m_ready generation for A ----------------
    int   ready_mode = 0;      // 0: always ready, 1: random, 2: manual
    logic man_ready  = 1'b1;
    logic rnd_ready  = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end
    assign m_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? rnd_ready : man_ready;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb [$];

    // Reference: a sweep of cnt words from base yields word i at address
    // (base+i) mod 2^24, index i, last only on i==cnt-1. Push the first n.
    task automatic push_words(input logic [AW-1:0] base, input int cnt, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + AW'(i);
            e.data = mem_word(e.addr);
            e.idx  = CW'(i);
            e.last = (i == cnt - 1);
            sb.push_back(e);
        end
    endtask

    int            done_cnt = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] p_data;
    logic [CW-1:0] p_index;
    logic [AW-1:0] p_addr;
    logic          p_last;
    exp_t          cur;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data",  32'(m_data),  32'(p_data));
                chk("hold_index", 32'(m_index), 32'(p_index));
                chk("hold_addr",  32'(rd_addr), 32'(p_addr));
                chk("hold_last",  32'(m_last),  32'(p_last));
            end
            if (m_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_word: got index %0d data 0x%0h, expected no word", m_index, m_data);
                end else begin
                    cur = sb[0];
                    chk("word_data",  32'(m_data),  32'(cur.data));
                    chk("word_index", 32'(m_index), 32'(cur.idx));
                    chk("word_last",  32'(m_last),  32'(cur.last));
                    chk("word_addr",  32'(rd_addr), 32'(cur.addr));
                    if (m_ready && !abort) begin
                        void'(sb.pop_front());
                        $display("word accepted: index=%0d addr=0x%06h data=0x%06h last=%0b",
                                 m_index, rd_addr, m_data, m_last);
                    end
                end
            end
            prev_hold = m_valid && !m_ready && !abort;
            p_data    = m_data;
            p_index   = m_index;
            p_addr    = rd_addr;
            p_last    = m_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] b, input logic [CW-1:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            tick();
            k++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no done pulse, expected one within 500 cycles", name);
        end
        repeat (3) tick();
        chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_busy_low"},  32'(busy), 32'd0);
        chk({name, "_drained"},   32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_index(input logic [CW-1:0] idx, input string name);
        int k;
        k = 0;
        while (!(m_valid && m_index == idx) && k < 100) begin
            tick();
            k++;
        end
        if (!(m_valid && m_index == idx)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no word with index %0d, expected one within 100 cycles", name, idx);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, k, bdone;
        logic [AW-1:0] rb;

        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
        b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_base = '0; b_count = '0;
        b_m_ready = 1'b1;
        repeat (4) tick();

        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_m_index", 32'(m_index), 32'd0);
        chk("rst_m_last",  32'(m_last),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        rst = 1'b0; b_rst = 1'b0;
        tick();

        // Basic sweep.
        ready_mode = 0;
        push_words(24'h000010, 3, 3);
        d0 = done_cnt;
        issue(24'h000010, 16'd3);
        wait_done(d0, "basic");

        // Backpressure on the second word.
        ready_mode = 2; man_ready = 1'b1;
        push_words(24'h000010, 3, 3);
        d0 = done_cnt;
        issue(24'h000010, 16'd3);
        wait_index(16'd1, "bp");
        man_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_data",  32'(m_data),  32'(mem_word(24'h000011)));
            chk("bp_index", 32'(m_index), 32'd1);
            chk("bp_addr",  32'(rd_addr), 32'h000011);
        end
        man_ready = 1'b1;
        wait_done(d0, "bp");

        // Address wrap-around with random backpressure.
        ready_mode = 1;
        push_words(24'hFFFFFE, 4, 4);
        d0 = done_cnt;
        issue(24'hFFFFFE, 16'd4);
        wait_done(d0, "wrap");

        // Zero-length sweep: done two cycles after start, no words.
        ready_mode = 0;
        d0 = done_cnt;
        issue(24'h000055, 16'd0);
        chk("zero_done_early", 32'(done), 32'd0);
        chk("zero_busy",       32'(busy), 32'd1);
        tick();
        chk("zero_done",       32'(done),    32'd1);
        chk("zero_no_valid",   32'(m_valid), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(done), 32'd0);
        chk("zero_done_count", 32'(done_cnt - d0), 32'd1);

        // Start while busy is ignored.
        push_words(24'h000300, 2, 2);
        d0 = done_cnt;
        issue(24'h000300, 16'd2);
        tick();
        issue(24'h000999, 16'd5);
        wait_done(d0, "ignore_start");

        // Abort in HOLD of word 1 with m_ready high in the same cycle.
        ready_mode = 2; man_ready = 1'b1;
        push_words(24'h000400, 8, 2);
        d0 = done_cnt;
        issue(24'h000400, 16'd8);
        wait_index(16'd1, "abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid_fall", 32'(m_valid), 32'd0);
        chk("abort_last_low",   32'(m_last),  32'd0);
        chk("abort_word_dropped", 32'(sb.size()), 32'd1);
        sb.delete();
        wait_done(d0, "abort");

        // Random sweeps after the abort.
        ready_mode = 1;
        for (int s = 0; s < 6; s++) begin
            rb = AW'($urandom);
            k  = $urandom_range(1, 6);
            push_words(rb, k, k);
            d0 = done_cnt;
            issue(rb, CW'(k));
            wait_done(d0, "random");
        end

        // Instance B: latency with RD_LAT = 3.
        b_base = 24'h000100; b_count = 16'd2; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("lat_addr", 32'(b_rd_addr), 32'h000100);
        k = 0;
        while (!b_m_valid && k < 20) begin
            tick();
            k++;
        end
        chk("lat_cycles", 32'(k), 32'd4);
        chk("lat_data",   32'(b_m_data), 32'(mem_word(24'h000100)));
        k = 0;
        while (b_busy && k < 50) begin
            tick();
            k++;
        end
        chk("lat_sweep_end", 32'(b_busy), 32'd0);
        repeat (2) tick();

        // Instance B: reset in the middle of WAIT.
        b_base = 24'h000200; b_count = 16'd3; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        b_rst = 1'b1;
        tick();
        chk("mrst_rd_addr", 32'(b_rd_addr), 32'd0);
        chk("mrst_m_valid", 32'(b_m_valid), 32'd0);
        chk("mrst_m_data",  32'(b_m_data),  32'd0);
        chk("mrst_m_index", 32'(b_m_index), 32'd0);
        chk("mrst_m_last",  32'(b_m_last),  32'd0);
        chk("mrst_busy",    32'(b_busy),    32'd0);
        b_rst = 1'b0;
        bdone = 0;
        for (int i = 0; i < 8; i++) begin
            if (b_done) bdone++;
            tick();
        end
        chk("mrst_no_done", 32'(bdone), 32'd0);
        chk("mrst_no_valid", 32'(b_m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/parallel_mem_reader.md
Name: parallel_mem_reader

Overview:
Host-side reader for the processor's debug read port (parallelAddress in, q out). On a start pulse it sweeps a contiguous address range. For each address it drives the address, waits out the memory read latency, captures the returned word, and offers it on a valid/ready output stream. It sits outside the processor and feeds a display, UART or logic-analyser sink.

Parameters:
AW, 24, width of the read address (matches the processor's parallelAddress).
DW, 24, width of the returned data word (matches the processor's q).
CW, 16, width of the word-count and index fields.
RD_LAT, 1, clock edges from a stable address to valid q; legal range 1..15.

Ports:
clk  input  1  system clock; one clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
abort  input  1  abandon the current sweep; takes priority over every other event.
base_addr  input  AW  first address of the sweep; latched on an accepted start.
word_count  input  CW  number of words to read; latched on an accepted start.
rd_addr  output  AW  address driven to the processor's parallelAddress.
rd_data  input  DW  word returned by the processor's q.
m_valid  output  1  output word available.
m_ready  input  1  sink accepts the word.
m_data  output  DW  captured word.
m_index  output  CW  offset of m_data from base_addr.
m_last  output  1  high with the final word of the sweep.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a sweep completes or is aborted.

Behaviour:
- Reset (synchronous): state IDLE; rd_addr=0; m_valid=0; m_data=0; m_index=0; m_last=0; busy=0; done=0; latency counter=0; remaining=0.
- States: IDLE, WAIT, HOLD, DONE.
- IDLE:
  - start=1 and word_count>0: latch base_addr and word_count; rd_addr<=base_addr; index<=0; latency counter<=RD_LAT; go to WAIT.
  - start=1 and word_count=0: go to DONE directly; no words are emitted.
  - start=0: stay in IDLE.
- WAIT:
  - rd_addr is held constant.
  - The latency counter decrements each cycle.
  - In the cycle the counter is 0: m_data<=rd_data, m_valid<=1, m_last<=(remaining==1); go to HOLD.
  - Latency: m_valid rises exactly RD_LAT+1 cycles after the first cycle rd_addr shows the new address.
- HOLD:
  - m_valid, m_data, m_index, m_last and rd_addr stay stable until m_valid&&m_ready.
  - On the handshake with remaining>1: m_valid<=0; remaining--; index++; rd_addr<=rd_addr+1; latency counter<=RD_LAT; go to WAIT.
  - On the handshake with remaining==1: m_valid<=0; m_last<=0; go to DONE.
  - m_ready while m_valid=0 has no effect.
- DONE: done=1 for exactly one cycle; go to IDLE. start is ignored in DONE.
- Throughput: one word per RD_LAT+2 cycles when m_ready is held high.
- Address arithmetic: rd_addr increments modulo 2^AW, so 0xFFFFFF is followed by 0x000000. m_index increments modulo 2^CW and cannot overflow because remaining<=2^CW-1.
- start while busy: ignored; latched base_addr and word_count are unchanged.
- abort in WAIT or HOLD: m_valid<=0 and m_last<=0 at the next edge; go to DONE. The in-flight word is dropped, even if m_ready is high in the same cycle.
- abort in IDLE or DONE: no effect.
- rst asserted mid-sweep: outputs take reset values at the next edge; done does not pulse.

Decomposition:
- Shared package mem_reader_pkg:
  - state enum typedef (IDLE, WAIT, HOLD, DONE);
  - localparams PAR_AW=24 and PAR_DW=24, shared with the processor's parallel-port widths.
- One natural sub-module, read_latency_timer: a loadable down-counter with a zero flag, reusable by other host-side peripherals.
- Datapath registers and the FSM live in the top module.

Test Plan:
- Basic sweep: RD_LAT=1, base=0x000010, count=3, m_ready=1, memory model returns addr^0xA5A5A5 with 1-cycle latency.
  -> Words 0xA5A5B5, 0xA5A5B4, 0xA5A5B7 with m_index 0, 1, 2.
  -> m_last only on index 2; done pulses once; busy low afterwards.
- Backpressure: same sweep with m_ready low for 5 cycles on the second word.
  -> m_data, m_index and rd_addr=0x000011 stay stable throughout; nothing is duplicated or lost.
- Wrap-around: base=0xFFFFFE, count=4.
  -> rd_addr sequence 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; m_index 0..3.
- Zero count and ignored start: start with count=0 -> no m_valid, done two cycles after start. Then a second start issued during a count=2 sweep -> ignored; exactly 2 words emitted.
- Abort: abort during HOLD of word 1 of a count=8 sweep, with m_ready=1 in the same cycle.
  -> m_valid falls next edge; no further words; done pulses once; a subsequent start works normally.
- Latency and reset: RD_LAT=3 -> m_valid rises 4 cycles after rd_addr changes. rst mid-WAIT -> all outputs at reset values next edge, and no done pulse.
